// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus sequencer: entry layout, FSM state codes
// and field widths. Optional build macro STIM_SEQ_WAIT_EN enables the WAIT
// handshake in stim_sequencer (see that file).
package stim_pkg;

   localparam int STIM_SW_W   = 16;
   localparam int STIM_DLY_W  = 16;
   localparam int STIM_FLAG_W = 5;
   localparam int STIM_ENTRY_W = STIM_SW_W + STIM_DLY_W + STIM_FLAG_W;

   // Packed table entry, MSB first: {LAST, WAIT, RST, CONT, RUN, DLY, S}
   typedef struct packed {
      logic                  last;
      logic                  wait_f;
      logic                  rst;
      logic                  cont;
      logic                  run;
      logic [STIM_DLY_W-1:0] dly;
      logic [STIM_SW_W-1:0]  s;
   } stim_entry_t;

   // FSM state codes
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_APPLY = 3'd1;
   localparam logic [2:0] ST_HOLD  = 3'd2;
   localparam logic [2:0] ST_WAITC = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Width of a packed entry for arbitrary switch/delay widths
   function automatic int entry_width(input int sw_w, input int dly_w);
      return sw_w + dly_w + STIM_FLAG_W;
   endfunction

endpackage

// File: rtl/stim_table.sv
// Entry storage for the stimulus sequencer: DEPTH x W register file with one
// synchronous write port and one asynchronous read port. Not reset.
module stim_table
   import stim_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = STIM_ENTRY_W
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Write one entry on the rising edge when enabled
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_sequencer.sv
// Plays back a table of switch vectors and active-low control pulses to a DUT.
// Each step: one APPLY cycle, then the pulse cycle plus DLY hold cycles, then
// either the next step or DONE. Build macro STIM_SEQ_WAIT_EN adds a WAITC
// state that stalls after the hold until wait_in is seen high.
module stim_sequencer
   import stim_pkg::*;
#(
   parameter int SW_W  = STIM_SW_W,
   parameter int DEPTH = 16,
   parameter int DLY_W = STIM_DLY_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          wr_en,
   input  logic [$clog2(DEPTH)-1:0]      wr_addr,
   input  logic [SW_W+DLY_W+STIM_FLAG_W-1:0] wr_data,
   input  logic                          wait_in,
   output logic [SW_W-1:0]               s_out,
   output logic                          run_n,
   output logic                          continue_n,
   output logic                          dut_reset_n,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(DEPTH)-1:0]      step_idx
);

   localparam int AW     = $clog2(DEPTH);
   localparam int EW     = entry_width(SW_W, DLY_W);
   localparam int RUN_B  = SW_W + DLY_W;
   localparam int CONT_B = RUN_B + 1;
   localparam int RST_B  = RUN_B + 2;
   localparam int WAIT_B = RUN_B + 3;
   localparam int LAST_B = RUN_B + 4;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [2:0]       state;
   logic [EW-1:0]    cur;
   logic [DLY_W-1:0] hold_cnt;
   logic [AW-1:0]    rd_addr;
   logic [EW-1:0]    rd_data;
   logic             tbl_we;
   logic             final_step;

   // The table is locked while a playback is in progress
   assign tbl_we = wr_en & ~busy;

   stim_table #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_table (
      .clk     (clk),
      .wr_en   (tbl_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign busy       = (state == ST_APPLY) || (state == ST_HOLD) || (state == ST_WAITC);
   assign done       = (state == ST_DONE);
   assign final_step = cur[LAST_B] || (step_idx == LAST_IDX);

`ifndef STIM_SEQ_WAIT_EN
   logic unused_wait;
   assign unused_wait = wait_in ^ cur[WAIT_B];
`endif

   // Read address is the entry about to be latched: 0 on Start, else the next step
   always_comb begin
      rd_addr = '0;
      if (busy) begin
         rd_addr = step_idx + 1'b1;
      end
   end

   // Sequencer FSM; the current entry is latched when entering APPLY so a
   // write on the Start edge cannot alter the step being launched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         step_idx    <= '0;
         s_out       <= '0;
         run_n       <= 1'b1;
         continue_n  <= 1'b1;
         dut_reset_n <= 1'b0;
         hold_cnt    <= '0;
         cur         <= '0;
      end else begin
         run_n       <= 1'b1;
         continue_n  <= 1'b1;
         dut_reset_n <= 1'b1;
         if (abort) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     state    <= ST_APPLY;
                     step_idx <= '0;
                     cur      <= rd_data;
                  end
               end
               ST_APPLY: begin
                  s_out       <= cur[SW_W-1:0];
                  run_n       <= ~cur[RUN_B];
                  continue_n  <= ~cur[CONT_B];
                  dut_reset_n <= ~cur[RST_B];
                  hold_cnt    <= cur[RUN_B-1:SW_W];
                  state       <= ST_HOLD;
               end
               ST_HOLD: begin
                  if (hold_cnt != '0) begin
                     hold_cnt <= hold_cnt - 1'b1;
`ifdef STIM_SEQ_WAIT_EN
                  end else if (cur[WAIT_B]) begin
                     state <= ST_WAITC;
`endif
                  end else if (final_step) begin
                     state <= ST_DONE;
                  end else begin
                     step_idx <= step_idx + 1'b1;
                     cur      <= rd_data;
                     state    <= ST_APPLY;
                  end
               end
`ifdef STIM_SEQ_WAIT_EN
               ST_WAITC: begin
                  if (wait_in) begin
                     if (final_step) begin
                        state <= ST_DONE;
                     end else begin
                        step_idx <= step_idx + 1'b1;
                        cur      <= rd_data;
                        state    <= ST_APPLY;
                     end
                  end
               end
`endif
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer. Expected cycle numbers are
// hand-computed: cycle 1 is the first cycle after the edge that samples Start.
module tb_stim_sequencer;
   import stim_pkg::*;

   localparam int AW = 4;
   localparam int EW = STIM_ENTRY_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort, wr_en, wait_in;
   logic [AW-1:0] wr_addr;
   logic [EW-1:0] wr_data;
   logic [15:0]   s_out;
   logic          run_n, continue_n, dut_reset_n, busy, done;
   logic [AW-1:0] step_idx;

   int num_compared   = 0;
   int num_mismatched = 0;

   int first_run, first_cont, first_rst, cnt_run, cnt_cont, cnt_rst;
   int done_cycle;
   logic [15:0]   s_at_run;
   logic [AW-1:0] step_at_done;
   logic          busy_at20;

   stim_sequencer #(.SW_W(16), .DEPTH(16), .DLY_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wait_in     (wait_in),
      .s_out       (s_out),
      .run_n       (run_n),
      .continue_n  (continue_n),
      .dut_reset_n (dut_reset_n),
      .busy        (busy),
      .done        (done),
      .step_idx    (step_idx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      num_compared++;
      if (got !== exp) begin
         num_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic stim_entry_t mkEntry(input logic last, input logic wt, input logic rst,
                                           input logic cont, input logic run,
                                           input logic [15:0] dly, input logic [15:0] s);
      stim_entry_t e;
      e.last = last; e.wait_f = wt; e.rst = rst; e.cont = cont; e.run = run;
      e.dly = dly; e.s = s;
      return e;
   endfunction

   // Write one entry while the sequencer is idle; drives just after an edge
   task automatic writeEntry(input logic [AW-1:0] a, input stim_entry_t e);
      wr_en = 1'b1; wr_addr = a; wr_data = e;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Drive start/abort for a single edge
   task automatic applyStimulus(input logic st, input logic ab);
      start = st; abort = ab;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
   endtask

   // Start a playback and record pulse/done timing for max_cycles cycles
   task automatic runTrace(input int max_cycles, input int abort_cycle, input int wr_cycle,
                           input logic [AW-1:0] wa, input stim_entry_t wd, input int wait_cycle);
      first_run = 0; first_cont = 0; first_rst = 0;
      cnt_run = 0; cnt_cont = 0; cnt_rst = 0; done_cycle = 0;
      s_at_run = 'x; step_at_done = 'x; busy_at20 = 1'bx;
      wait_in = 1'b0;
      start = 1'b1;
      if (wr_cycle == 0) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
      for (int n = 1; n <= max_cycles; n++) begin
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0; wr_en = 1'b0;
         if (!run_n) begin
            cnt_run++;
            if (first_run == 0) begin first_run = n; s_at_run = s_out; end
         end
         if (!continue_n) begin cnt_cont++; if (first_cont == 0) first_cont = n; end
         if (!dut_reset_n) begin cnt_rst++; if (first_rst == 0) first_rst = n; end
         if (done && done_cycle == 0) begin done_cycle = n; step_at_done = step_idx; end
         if (n == 20) busy_at20 = busy;
         if (n == abort_cycle) abort = 1'b1;
         if (n == wr_cycle) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
         if (n == wait_cycle) wait_in = 1'b1;
      end
      wait_in = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_s_out"}, s_out, 0);
      checkOutput({tag, "_run_n"}, run_n, 1);
      checkOutput({tag, "_continue_n"}, continue_n, 1);
      checkOutput({tag, "_dut_reset_n"}, dut_reset_n, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_step_idx"}, step_idx, 0);
   endtask

   task automatic checkMainTable(input string tag);
      checkOutput({tag, "_first_rst"}, first_rst, 2);
      checkOutput({tag, "_first_run"}, first_run, 6);
      checkOutput({tag, "_first_cont"}, first_cont, 58);
      checkOutput({tag, "_done_cycle"}, done_cycle, 59);
      checkOutput({tag, "_pulse_widths"}, {cnt_rst[7:0], cnt_run[7:0], cnt_cont[7:0]}, 24'h010101);
      checkOutput({tag, "_s_at_run"}, s_at_run, 16'h000B);
      checkOutput({tag, "_busy_mid"}, busy_at20, 1);
      checkOutput({tag, "_step_at_done"}, step_at_done, 2);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; wait_in = 1'b0;
      wr_addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");

      // Release reset away from the edge; dut_reset_n rises on the next edge
      rst_n = 1'b1;
      #1;
      checkOutput("rst_release_pre_edge", dut_reset_n, 0);
      @(posedge clk); #1;
      checkOutput("rst_release_post_edge", dut_reset_n, 1);

      // Three-step table: reset pulse, run pulse with long hold, last continue
      writeEntry(4'd0, mkEntry(0, 0, 1, 0, 0, 16'd2,  16'h0000));
      writeEntry(4'd1, mkEntry(0, 0, 0, 0, 1, 16'd50, 16'h000B));
      writeEntry(4'd2, mkEntry(1, 0, 0, 1, 0, 16'd0,  16'h0000));
      runTrace(64, -1, -1, '0, '0, -1);
      checkMainTable("main");
      checkOutput("main_s_out_end", s_out, 16'h0000);
      checkOutput("main_done_held", done, 1);

      // Abort during the hold of entry 1
      runTrace(15, 10, -1, '0, '0, -1);
      checkOutput("abort_first_run", first_run, 6);
      checkOutput("abort_no_more_pulses", {cnt_run[7:0], cnt_cont[7:0]}, 16'h0100);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_s_out", s_out, 16'h000B);
      checkOutput("abort_pulses_high", {run_n, continue_n, dut_reset_n}, 3'b111);

      // Reset asserted mid-hold acts immediately, then replay from entry 0
      runTrace(10, -1, -1, '0, '0, -1);
      checkOutput("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #2;
      checkResetState("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid_reset_release", dut_reset_n, 1);
      runTrace(64, -1, -1, '0, '0, -1);
      checkMainTable("replay");

      // Abort beats a simultaneous Start, also clears Done
      applyStimulus(1'b1, 1'b1);
      checkOutput("abort_wins_busy", busy, 0);
      checkOutput("abort_wins_done", done, 0);

      // Full table, no LAST: playback ends after the final entry
      for (int i = 0; i < 16; i++) begin
         writeEntry(4'(i), mkEntry(0, 0, 0, 0, 1, 16'd0, 16'h0014));
      end
      runTrace(36, -1, 5, 4'd0, mkEntry(1, 0, 0, 0, 1, 16'd0, 16'hFFFF), -1);
      checkOutput("full_done_cycle", done_cycle, 33);
      checkOutput("full_run_count", cnt_run, 16);
      checkOutput("full_step_at_done", step_at_done, 15);
      checkOutput("full_s_out", s_out, 16'h0014);

      // Locked-table write was dropped; a write concurrent with Start is not seen yet
      runTrace(36, -1, 0, 4'd0, mkEntry(1, 0, 0, 0, 1, 16'd0, 16'h00AA), -1);
      checkOutput("locked_s_at_run", s_at_run, 16'h0014);
      checkOutput("concurrent_done_cycle", done_cycle, 33);

      // The concurrent write did land and is used by the next playback
      runTrace(6, -1, -1, '0, '0, -1);
      checkOutput("newentry_s_at_run", s_at_run, 16'h00AA);
      checkOutput("newentry_done_cycle", done_cycle, 3);
      checkOutput("newentry_run_count", cnt_run, 1);

      // WAIT handshake: wait_in raised at cycle 32
      writeEntry(4'd0, mkEntry(0, 1, 0, 0, 1, 16'd0, 16'h0001));
      writeEntry(4'd1, mkEntry(1, 0, 0, 1, 0, 16'd0, 16'h0002));
      runTrace(40, -1, -1, '0, '0, 32);
      checkOutput("wait_first_run", first_run, 2);
`ifdef STIM_SEQ_WAIT_EN
      checkOutput("wait_first_cont", first_cont, 34);
      checkOutput("wait_done_cycle", done_cycle, 35);
      checkOutput("wait_busy_stalled", busy_at20, 1);
`else
      checkOutput("nowait_first_cont", first_cont, 4);
      checkOutput("nowait_done_cycle", done_cycle, 5);
      checkOutput("nowait_busy_at20", busy_at20, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameters SHALL be: SW_W 16 switch-vector width; DEPTH 16 table entries (power of two, >=2); DLY_W 16 hold-counter width.
REQ-002 Clk  in  1  sole clock, all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Start  in  1  begin playback at entry 0.
REQ-005 Abort  in  1  stop playback, return to IDLE.
REQ-006 Wr_en  in  1  write one table entry.
REQ-007 Wr_addr  in  $clog2(DEPTH)  entry index.
REQ-008 Wr_data  in  SW_W+DLY_W+5  packed entry {LAST, WAIT, RST, CONT, RUN, DLY, S}.
REQ-009 Wait_in  in  1  DUT-ready/halted indication.
REQ-010 S_out  out  SW_W  switch vector driven to DUT.
REQ-011 Run_n, Continue_n, Dut_reset_n  out  1 each  active-low DUT control pulses.
REQ-012 Busy, Done  out  1 each  status; Step_idx  out  $clog2(DEPTH)  current entry.

Function
REQ-013 FSM states SHALL be IDLE, APPLY, HOLD, WAITC, DONE.
REQ-014 IDLE/DONE: Start=1 sampled -> APPLY with Step_idx=0; Done cleared on that edge.
REQ-015 APPLY lasts exactly one cycle; on its closing edge S_out loads entry.S and each of Run_n/Continue_n/Dut_reset_n goes low iff its bit is set.
REQ-016 Pulse outputs SHALL be registered, low for exactly one cycle, high otherwise.
REQ-017 HOLD SHALL last exactly DLY cycles after the pulse cycle; DLY=0 skips HOLD.
REQ-018 After hold: WAIT set (macro on) -> WAITC until Wait_in=1 sampled; otherwise proceed.
REQ-019 Proceed: LAST=1 or Step_idx=DEPTH-1 -> DONE; else Step_idx+1 -> APPLY.
REQ-020 Start to first pulse latency SHALL be 2 cycles; step pitch SHALL be 2+DLY cycles without WAIT.
REQ-021 Busy=1 in APPLY/HOLD/WAITC; Done=1 held in DONE until Start or Abort.
REQ-022 Start while Busy SHALL be ignored; Wr_en while Busy SHALL be ignored (table locked).
REQ-023 Abort=1 SHALL force IDLE next edge from any state, release pulses high, keep S_out; Abort wins over simultaneous Start.
REQ-024 Wr_en in IDLE/DONE SHALL update the entry on the edge; concurrent Start reads the old contents of entry 0.

Reset
REQ-025 Reset low SHALL force: state IDLE, Step_idx 0, S_out 0, Run_n 1, Continue_n 1, Dut_reset_n 0, Busy 0, Done 0.
REQ-026 Dut_reset_n SHALL return to 1 on the first edge after Reset releases.
REQ-027 Table contents SHALL NOT be reset; reset mid-playback aborts with no further pulses.

Configuration
REQ-028 Macro STIM_SEQ_WAIT_EN defined: WAIT bit and WAITC state active per REQ-018.
REQ-029 Macro undefined: WAIT bit ignored, WAITC absent, Wait_in unused; all other timing identical.

Structure
REQ-030 Package stim_pkg SHALL hold the entry struct typedef, state enum, and field-width localparams derived from SW_W/DLY_W.
REQ-031 Sub-module stim_table SHALL implement the DEPTH-entry register file: one synchronous write port, one asynchronous read port.

Verification
REQ-032 Table {RST,DLY=2},{RUN,S=000B,DLY=50},{CONT,DLY=0,LAST}; Start -> Dut_reset_n low cycle 2, Run_n low cycle 6, Continue_n low cycle 58, Done cycle 59.
REQ-033 Entry S=0014, DLY=0, no LAST, all DEPTH entries -> Step_idx wraps nowhere, Done after entry 15.
REQ-034 Abort during HOLD of entry 1 -> IDLE next cycle, Run_n/Continue_n high, S_out stays 000B, Busy 0.
REQ-035 STIM_SEQ_WAIT_EN, entry WAIT set, Wait_in held 0 for 30 cycles then 1 -> next APPLY one cycle after Wait_in sampled high; macro off -> WAIT ignored.
REQ-036 Reset asserted mid-HOLD -> outputs per REQ-025 immediately; Start after release replays from entry 0 with unchanged table.
